// File: rtl/ctrlpim_pkg.sv
// Shared types for the mMPU control path: memory-op encoding, descriptor
// layout, sequencer states and default address/row widths.
package ctrlpim_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int ROW_W_DEF  = 10;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_LOGIC = 2'b11
  } mem_op_e;

  typedef struct packed {
    mem_op_e                 mem_op;
    logic [ADDR_W_DEF-1:0]   dest;
    logic [ADDR_W_DEF-1:0]   src1;
    logic [ADDR_W_DEF-1:0]   src2;
    logic [ROW_W_DEF-1:0]    row_start;
    logic [ROW_W_DEF-1:0]    row_end;
  } mmpu_desc_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/mmpu_desc_fifo.sv
// Synchronous descriptor FIFO with flush. Also reports next-cycle full/empty
// so the owner can register its ready/busy outputs without extra latency.
module mmpu_desc_fifo
  import ctrlpim_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  mmpu_desc_t wdata,
  output mmpu_desc_t rdata,
  output logic       full,
  output logic       empty,
  output logic       full_nxt,
  output logic       empty_nxt
);

  localparam int PW = $clog2(DEPTH) + 1;

  mmpu_desc_t      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_q[rd_ptr_q[PW-2:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
    full_nxt  = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);
    empty_nxt = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-2:0]] <= wdata;
  end

endmodule

// File: rtl/mmpu_issue_sequencer.sv
// Expands queued mMPU descriptors into one crossbar command per row.
// Optional perf counters are enabled with `define CTRLPIM_PERF_CNT_EN.
module mmpu_issue_sequencer
  import ctrlpim_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [1:0]        desc_mem_op,
  input  logic [ADDR_W-1:0] desc_dest,
  input  logic [ADDR_W-1:0] desc_src1,
  input  logic [ADDR_W-1:0] desc_src2,
  input  logic [ROW_W-1:0]  desc_row_start,
  input  logic [ROW_W-1:0]  desc_row_end,
  input  logic              abort,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_mem_op,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [ADDR_W-1:0] cmd_dest,
  output logic [ADDR_W-1:0] cmd_src1,
  output logic [ADDR_W-1:0] cmd_src2,
  output logic              cmd_last,
  output logic              op_done,
  output logic              busy
`ifdef CTRLPIM_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall
`endif
);

  mmpu_desc_t        wdesc, head;
  logic              fifo_full, fifo_empty, full_nxt, empty_nxt;
  logic              push, pop, flush, load, hs, at_last;

  seq_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic [ROW_W-1:0]  row_q, row_d, row_end_q, row_end_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              busy_q, busy_d;
  logic              desc_ready_q, desc_ready_d;

  always_comb begin
    wdesc.mem_op    = mem_op_e'(desc_mem_op);
    wdesc.dest      = desc_dest;
    wdesc.src1      = desc_src1;
    wdesc.src2      = desc_src2;
    wdesc.row_start = desc_row_start;
    wdesc.row_end   = desc_row_end;
  end

  // A push offered in the abort cycle is dropped along with the flush.
  assign push    = desc_valid && desc_ready_q && !abort;
  assign hs      = cmd_valid_q && cmd_ready;
  assign at_last = (row_q == row_end_q);

  mmpu_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wdata     (wdesc),
    .rdata     (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_nxt  (full_nxt),
    .empty_nxt (empty_nxt)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dest_d    = dest_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    row_d     = row_q;
    row_end_d = row_end_q;
    pop       = 1'b0;
    flush     = 1'b0;
    load      = 1'b0;
    if (abort) begin
      flush   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop  = 1'b1;
            load = (head.mem_op != MEM_NOP);
          end
        end
        S_ISSUE: begin
          if (hs) begin
            if (!at_last) begin
              row_d = row_q + 1'b1;
            end else if (!fifo_empty && head.mem_op != MEM_NOP) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              // A NOP head is left for IDLE to discard.
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (load) begin
      state_d   = S_ISSUE;
      op_d      = head.mem_op;
      dest_d    = head.dest;
      src1_d    = head.src1;
      src2_d    = head.src2;
      row_d     = head.row_start;
      row_end_d = head.row_end;
    end
    cmd_valid_d  = (state_d == S_ISSUE);
    busy_d       = !abort && (!empty_nxt || state_d != S_IDLE);
    desc_ready_d = !full_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= MEM_NOP;
      dest_q       <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      row_q        <= '0;
      row_end_q    <= '0;
      cmd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      desc_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dest_q       <= dest_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      row_q        <= row_d;
      row_end_q    <= row_end_d;
      cmd_valid_q  <= cmd_valid_d;
      busy_q       <= busy_d;
      desc_ready_q <= desc_ready_d;
    end
  end

  assign desc_ready = desc_ready_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_mem_op = op_q;
  assign cmd_row    = row_q;
  assign cmd_dest   = dest_q;
  assign cmd_src1   = src1_q;
  assign cmd_src2   = src2_q;
  assign cmd_last   = cmd_valid_q && at_last;
  assign op_done    = hs && at_last && !abort;
  assign busy       = busy_q;

`ifdef CTRLPIM_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_issued_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (hs && perf_issued_q != 32'hFFFF_FFFF)
      perf_issued_d = perf_issued_q + 32'd1;
    if (cmd_valid_q && !cmd_ready && perf_stall_q != 32'hFFFF_FFFF)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
